// File: rtl/video_sync_tracker.sv
// Video input timing tracker: registers the sync/data inputs once and tags each
// pixel with x/y and block coordinates, line/frame markers and a geometry lock.
module video_sync_tracker #(
    parameter int H_WIDTH  = 1920,
    parameter int V_HEIGHT = 1080,
    parameter int KH       = 30,
    parameter int KV       = 30
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  vs_i,
    input  logic                                  hs_i,
    input  logic                                  de_i,
    input  logic [23:0]                           data_i,
    output logic                                  vs_o,
    output logic                                  hs_o,
    output logic                                  de_o,
    output logic [23:0]                           data_o,
    output logic                                  pix_valid_o,
    output logic [$clog2(H_WIDTH+1)-1:0]          x_o,
    output logic [$clog2(V_HEIGHT+1)-1:0]         y_o,
    output logic [$clog2(H_WIDTH/KH+2)-1:0]       bx_o,
    output logic [$clog2(V_HEIGHT/KV+2)-1:0]      by_o,
    output logic                                  sof_o,
    output logic                                  eol_o,
    output logic                                  eof_o,
    output logic                                  locked_o,
    output logic                                  err_o,
    output logic [15:0]                           frame_cnt_o
);
    localparam int XW  = $clog2(H_WIDTH+1);
    localparam int YW  = $clog2(V_HEIGHT+1);
    localparam int BXW = $clog2(H_WIDTH/KH+2);
    localparam int BYW = $clog2(V_HEIGHT/KV+2);
    localparam int KXW = $clog2(KH+1);
    localparam int KYW = $clog2(KV+1);

    localparam logic [XW-1:0]  X_END   = XW'(H_WIDTH);
    localparam logic [XW-1:0]  X_LAST  = XW'(H_WIDTH-1);
    localparam logic [YW-1:0]  Y_END   = YW'(V_HEIGHT);
    localparam logic [YW-1:0]  Y_LAST  = YW'(V_HEIGHT-1);
    localparam logic [KXW-1:0] KX_LAST = KXW'(KH-1);
    localparam logic [KYW-1:0] KY_LAST = KYW'(KV-1);

    typedef enum logic {SEEK, ACTIVE} state_t;

    state_t state_q, state_d;

    logic [XW-1:0]  x_cnt, x_a, x_d;
    logic [YW-1:0]  y_cnt, y_a, y_d;
    logic [KXW-1:0] kx_cnt, kx_a, kx_d;
    logic [KYW-1:0] ky_cnt, ky_a, ky_d;
    logic [BXW-1:0] bx_cnt, bx_a, bx_d;
    logic [BYW-1:0] by_cnt, by_a, by_d;
    logic           bad_q, bad_a, bad_d;

    logic vs_rise, de_fall, act, frame_close, good_frame, pix, in_range;

    // Edge detection uses the registered copies of vs/de as the previous sample.
    assign vs_rise     = vs_i && !vs_o;
    assign de_fall     = !de_i && de_o;
    assign act         = (state_q == ACTIVE) || vs_rise;
    assign frame_close = (state_q == ACTIVE) && vs_rise;
    assign good_frame  = !bad_q && (y_cnt == Y_END);
    assign pix         = act && de_i;

    // FSM next state: leave SEEK on the first vs rising edge, then stay ACTIVE.
    always_comb begin
        state_d = state_q;
        if (state_q == SEEK && vs_rise)
            state_d = ACTIVE;
    end

    // Counter update: frame/line close first (stage a), then count this pixel.
    always_comb begin
        x_a = x_cnt; kx_a = kx_cnt; bx_a = bx_cnt;
        y_a = y_cnt; ky_a = ky_cnt; by_a = by_cnt;
        bad_a = bad_q;
        if (vs_rise) begin
            // A vs edge wins over a coincident de fall: that line is discarded.
            x_a = '0; kx_a = '0; bx_a = '0;
            y_a = '0; ky_a = '0; by_a = '0;
            bad_a = 1'b0;
        end else if (state_q == ACTIVE && de_fall) begin
            if (x_cnt != X_END)
                bad_a = 1'b1;
            x_a = '0; kx_a = '0; bx_a = '0;
            if (y_cnt < Y_END) begin
                y_a = y_cnt + 1'b1;
                if (ky_cnt == KY_LAST) begin
                    ky_a = '0;
                    by_a = by_cnt + 1'b1;
                end else begin
                    ky_a = ky_cnt + 1'b1;
                end
            end
        end

        in_range = (x_a < X_END) && (y_a < Y_END);

        x_d = x_a; kx_d = kx_a; bx_d = bx_a;
        y_d = y_a; ky_d = ky_a; by_d = by_a;
        bad_d = bad_a;
        if (pix) begin
            if (y_a >= Y_END)
                bad_d = 1'b1;
            // Block counters stop with x so bx never runs past H_WIDTH/KH.
            if (x_a < X_END) begin
                x_d = x_a + 1'b1;
                if (kx_a == KX_LAST) begin
                    kx_d = '0;
                    bx_d = bx_a + 1'b1;
                end else begin
                    kx_d = kx_a + 1'b1;
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= SEEK;
        else         state_q <= state_d;
    end

    // Counters, pass-through registers and all annotated outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_cnt <= '0; kx_cnt <= '0; bx_cnt <= '0;
            y_cnt <= '0; ky_cnt <= '0; by_cnt <= '0;
            bad_q <= 1'b0;
            vs_o <= 1'b0; hs_o <= 1'b0; de_o <= 1'b0; data_o <= '0;
            pix_valid_o <= 1'b0;
            x_o <= '0; y_o <= '0; bx_o <= '0; by_o <= '0;
            sof_o <= 1'b0; eol_o <= 1'b0; eof_o <= 1'b0;
            locked_o <= 1'b0; err_o <= 1'b0; frame_cnt_o <= '0;
        end else begin
            x_cnt <= x_d; kx_cnt <= kx_d; bx_cnt <= bx_d;
            y_cnt <= y_d; ky_cnt <= ky_d; by_cnt <= by_d;
            bad_q <= bad_d;
            vs_o <= vs_i; hs_o <= hs_i; de_o <= de_i; data_o <= data_i;
            pix_valid_o <= pix && in_range;
            x_o  <= x_a;
            y_o  <= y_a;
            bx_o <= bx_a;
            by_o <= by_a;
            sof_o <= pix && in_range && (x_a == '0) && (y_a == '0);
            eol_o <= pix && in_range && (x_a == X_LAST);
            eof_o <= pix && in_range && (x_a == X_LAST) && (y_a == Y_LAST);
            err_o <= frame_close && !good_frame;
            if (frame_close) begin
                locked_o <= good_frame;
                if (good_frame)
                    frame_cnt_o <= frame_cnt_o + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_video_sync_tracker.sv
// Directed bench for video_sync_tracker on a small 8x4 geometry with 3x3 blocks.
module tb_video_sync_tracker;
    localparam int H  = 8;
    localparam int V  = 4;
    localparam int KH = 3;
    localparam int KV = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vs_i, hs_i, de_i;
    logic [23:0] data_i;
    logic        vs_o, hs_o, de_o;
    logic [23:0] data_o;
    logic        pix_valid_o;
    logic [3:0]  x_o;
    logic [2:0]  y_o;
    logic [1:0]  bx_o;
    logic [1:0]  by_o;
    logic        sof_o, eol_o, eof_o, locked_o, err_o;
    logic [15:0] frame_cnt_o;

    video_sync_tracker #(.H_WIDTH(H), .V_HEIGHT(V), .KH(KH), .KV(KV)) dut (
        .clk_i(clk), .rst_ni(rst_n), .vs_i(vs_i), .hs_i(hs_i), .de_i(de_i),
        .data_i(data_i), .vs_o(vs_o), .hs_o(hs_o), .de_o(de_o), .data_o(data_o),
        .pix_valid_o(pix_valid_o), .x_o(x_o), .y_o(y_o), .bx_o(bx_o), .by_o(by_o),
        .sof_o(sof_o), .eol_o(eol_o), .eof_o(eof_o), .locked_o(locked_o),
        .err_o(err_o), .frame_cnt_o(frame_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vs, hs, de;
        logic [23:0] data;
        logic        chk_xy;
        logic        pv;
        int          x, y, bx, by;
        logic        sof, eol, eof;
        logic        locked, err;
        int          cnt;
    } vec_t;

    vec_t vecs[$];
    logic cur_locked;
    int   cur_cnt;
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string nm, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    task automatic add_blank(input logic vs, input logic err);
        vec_t v;
        v.vs = vs; v.hs = 1'b1; v.de = 1'b0; v.data = 24'($urandom);
        v.chk_xy = 1'b0; v.pv = 1'b0;
        v.x = 0; v.y = 0; v.bx = 0; v.by = 0;
        v.sof = 1'b0; v.eol = 1'b0; v.eof = 1'b0;
        v.locked = cur_locked; v.err = err; v.cnt = cur_cnt;
        vecs.push_back(v);
    endtask

    // One line of w pixels on row y followed by two blank cycles; vs_lead
    // raises vs together with the first two pixels.
    task automatic add_line(input int y, input int w, input logic vs_lead);
        for (int i = 0; i < w; i++) begin
            vec_t v;
            v.vs = vs_lead && (i < 2); v.hs = 1'b0; v.de = 1'b1;
            v.data = 24'($urandom);
            v.chk_xy = 1'b1;
            v.x  = (i < H) ? i : H;
            v.y  = (y < V) ? y : V;
            v.bx = v.x / KH;
            v.by = v.y / KV;
            v.pv = (i < H) && (y < V);
            v.sof = v.pv && (i == 0) && (y == 0);
            v.eol = v.pv && (i == H-1);
            v.eof = v.eol && (y == V-1);
            v.locked = cur_locked; v.err = 1'b0; v.cnt = cur_cnt;
            vecs.push_back(v);
        end
        add_blank(1'b0, 1'b0);
        add_blank(1'b0, 1'b0);
    endtask

    task automatic add_vs(input logic err, input logic locked, input int cnt);
        cur_locked = locked;
        cur_cnt    = cnt;
        add_blank(1'b1, err);
        add_blank(1'b1, 1'b0);
        add_blank(1'b0, 1'b0);
        add_blank(1'b0, 1'b0);
    endtask

    task automatic add_frame(input int nl, input int short_line);
        for (int y = 0; y < nl; y++)
            add_line(y, (y == short_line) ? H-1 : H, 1'b0);
    endtask

    task automatic drive(input logic vs, input logic de, input logic [23:0] d);
        vs_i = vs; hs_i = !de; de_i = de; data_i = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vs_i = 1'b1; hs_i = 1'b1; de_i = 1'b1; data_i = 24'hABCDEF;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Outputs must stay cleared while reset is held with busy inputs.
        chk("rst de_o", de_o, 0);
        chk("rst data_o", data_o, 0);
        chk("rst pix_valid", pix_valid_o, 0);
        chk("rst locked", locked_o, 0);
        chk("rst frame_cnt", frame_cnt_o, 0);

        // Out of reset with de but no vs edge: tracker is seeking.
        vs_i = 1'b0;
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 24'h000111);
        drive(1'b0, 1'b1, 24'h000222);
        chk("seek de_o", de_o, 1);
        chk("seek pix_valid", pix_valid_o, 0);
        chk("seek x_o", x_o, 0);

        // Open a frame and start a line, then reset in the middle of it.
        drive(1'b0, 1'b0, 24'h0);
        drive(1'b1, 1'b0, 24'h0);
        drive(1'b0, 1'b1, 24'h000010);
        drive(1'b0, 1'b1, 24'h000011);
        drive(1'b0, 1'b1, 24'h000012);
        chk("pre-rst x_o", x_o, 2);
        chk("pre-rst pix_valid", pix_valid_o, 1);
        rst_n = 1'b0;
        #1;
        chk("midline rst pix_valid", pix_valid_o, 0);
        chk("midline rst x_o", x_o, 0);
        chk("midline rst de_o", de_o, 0);
        @(posedge clk);
        #1;
        vs_i = 1'b0; de_i = 1'b0;
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 24'h0);

        // Build the frame sequence table.
        cur_locked = 1'b0;
        cur_cnt    = 0;
        add_blank(1'b0, 1'b0);
        add_vs(1'b0, 1'b0, 0);  add_frame(4, -1);   // frame 1 from SEEK
        add_vs(1'b0, 1'b1, 1);  add_frame(4, -1);   // frame 1 good
        add_vs(1'b0, 1'b1, 2);  add_frame(4, 1);    // frame 2 good; frame 3 short line
        add_vs(1'b1, 1'b0, 2);  add_frame(5, -1);   // frame 3 bad; frame 4 has 5 lines
        add_vs(1'b1, 1'b0, 2);  add_frame(4, -1);   // frame 4 bad
        cur_locked = 1'b1;                          // frame 5 closed by vs with de=1
        cur_cnt    = 3;
        add_line(0, H, 1'b1);
        for (int y = 1; y < V; y++) add_line(y, H, 1'b0);
        add_vs(1'b0, 1'b1, 4);                      // frame 6 good

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            vs_i = v.vs; hs_i = v.hs; de_i = v.de; data_i = v.data;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d data_o", i), data_o, v.data);
            chk($sformatf("v%0d de_o", i), de_o, v.de);
            chk($sformatf("v%0d vs_o", i), vs_o, v.vs);
            chk($sformatf("v%0d pix_valid", i), pix_valid_o, v.pv);
            chk($sformatf("v%0d locked", i), locked_o, v.locked);
            chk($sformatf("v%0d err", i), err_o, v.err);
            chk($sformatf("v%0d frame_cnt", i), frame_cnt_o, v.cnt);
            if (v.chk_xy) begin
                chk($sformatf("v%0d x_o", i), x_o, v.x);
                chk($sformatf("v%0d y_o", i), y_o, v.y);
                chk($sformatf("v%0d bx_o", i), bx_o, v.bx);
                chk($sformatf("v%0d by_o", i), by_o, v.by);
                chk($sformatf("v%0d sof", i), sof_o, v.sof);
                chk($sformatf("v%0d eol", i), eol_o, v.eol);
                chk($sformatf("v%0d eof", i), eof_o, v.eof);
            end
        end

        // Random stream: every pass-through output is the input one cycle later.
        for (int i = 0; i < 40; i++) begin
            logic        rv, rh, rd;
            logic [23:0] rdat;
            rv = 1'($urandom); rh = 1'($urandom); rd = 1'($urandom);
            rdat = 24'($urandom);
            vs_i = rv; hs_i = rh; de_i = rd; data_i = rdat;
            @(posedge clk);
            #1;
            chk($sformatf("rnd%0d data_o", i), data_o, rdat);
            chk($sformatf("rnd%0d vs_o", i), vs_o, rv);
            chk($sformatf("rnd%0d hs_o", i), hs_o, rh);
            chk($sformatf("rnd%0d de_o", i), de_o, rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
